// File: rtl/spi_slave.sv
// SPI slave for all four CPOL/CPHA modes. SCLK, CS and MOSI are re-timed into
// clk_i; words are exchanged with the host through tx_load_o / rx_valid_o pulses.
module spi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  sclk_i,
    input  logic                  cs_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_load_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o
);
    localparam int            CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic                  r_cs_s1, r_cs_s2;
    logic                  r_mosi_s1, r_mosi_s2;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_tx_sr, w_tx_sr_nxt;
    logic [DATA_WIDTH-2:0] r_rx_sr, w_rx_sr_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  r_miso, w_miso_nxt;
    logic                  r_first, w_first_nxt;
    logic                  w_load;
    logic                  w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
    logic                  w_reload;
    logic [DATA_WIDTH-1:0] w_rx_word;

    // Pin synchronizers idle at the bus rest levels so reset release is not seen as an edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sclk_s1 <= CPOL;
            r_sclk_s2 <= CPOL;
            r_sclk_d  <= CPOL;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk_i;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_cs_s1   <= cs_i;
            r_cs_s2   <= r_cs_s1;
            r_mosi_s1 <= mosi_i;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_rise    = r_sclk_s2 & ~r_sclk_d;
    assign w_fall    = ~r_sclk_s2 & r_sclk_d;
    assign w_lead    = CPOL ? w_fall : w_rise;
    assign w_trail   = CPOL ? w_rise : w_fall;
    assign w_sample  = CPHA ? w_trail : w_lead;
    assign w_shift   = CPHA ? w_lead : w_trail;
    assign w_rx_word = {r_rx_sr, r_mosi_s2};
    // A shift edge at count 0 starts a new word, except the very first CPHA=1 word,
    // whose data was already captured when CS fell.
    assign w_reload  = (r_cnt == '0) && (!CPHA || !r_first);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b0;
            r_first    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_sr    <= w_tx_sr_nxt;
            r_rx_sr    <= w_rx_sr_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_miso     <= w_miso_nxt;
            r_first    <= w_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tx_sr_nxt    = r_tx_sr;
        w_rx_sr_nxt    = r_rx_sr;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_miso_nxt     = r_miso;
        w_first_nxt    = r_first;
        w_load         = 1'b0;
        case (r_state)
            IDLE: begin
                w_miso_nxt = 1'b0;
                if (!r_cs_s2) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = '0;
                    w_rx_sr_nxt = '0;
                    w_first_nxt = 1'b1;
                    w_load      = 1'b1;
                    w_tx_sr_nxt = tx_data_i;
                    if (!CPHA) begin
                        w_miso_nxt  = tx_data_i[DATA_WIDTH-1];
                        w_tx_sr_nxt = {tx_data_i[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            ACTIVE: begin
                if (r_cs_s2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_rx_sr_nxt = '0;
                    w_miso_nxt  = 1'b0;
                end else if (w_sample) begin
                    w_rx_sr_nxt = w_rx_word[DATA_WIDTH-2:0];
                    if (r_cnt == LAST) begin
                        w_cnt_nxt      = '0;
                        w_rx_data_nxt  = w_rx_word;
                        w_rx_valid_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (w_shift) begin
                    w_first_nxt = 1'b0;
                    if (w_reload) begin
                        w_load      = 1'b1;
                        w_miso_nxt  = tx_data_i[DATA_WIDTH-1];
                        w_tx_sr_nxt = {tx_data_i[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        w_miso_nxt  = r_tx_sr[DATA_WIDTH-1];
                        w_tx_sr_nxt = {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
        endcase
    end

    assign miso_o     = r_miso;
    assign miso_oe_o  = (r_state == ACTIVE);
    assign busy_o     = (r_state == ACTIVE);
    assign tx_load_o  = w_load;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bit-level master model, and a
// scoreboard that checks every rx_valid_o pulse against the words the master sent.
module tb_spi_slave;
    localparam int HALF = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [3:0]      sclk, cs_n, mosi;
    wire  [3:0]      miso, oe, busy, load, rxv;
    logic [3:0][7:0] txd;
    wire  [3:0][7:0] rxd;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         load_cnt [4];
    logic [7:0] exp_rx [$];
    logic [7:0] txq [$];
    logic [7:0] mw [$];
    logic [7:0] tw [$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .DATA_WIDTH (8),
            .CPOL       ((g / 2) == 1),
            .CPHA       ((g % 2) == 1)
        ) u_dut (
            .clk_i      (clk),
            .rstn_i     (rstn),
            .sclk_i     (sclk[g]),
            .cs_i       (cs_n[g]),
            .mosi_i     (mosi[g]),
            .miso_o     (miso[g]),
            .miso_oe_o  (oe[g]),
            .tx_data_i  (txd[g]),
            .tx_load_o  (load[g]),
            .rx_data_o  (rxd[g]),
            .rx_valid_o (rxv[g]),
            .busy_o     (busy[g])
        );
    end

    task automatic check(input string name, input int m, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s mode%0d: got %0h, expected %0h", name, m, act, exp);
        end
    endtask

    // Master transfer of nbits bits, MSB first. With CPHA=0 the master releases CS
    // in the same instant SCLK returns to idle after the last bit.
    task automatic xfer(input int m, input int nbits, input bit do_rst);
        bit         cpol, cpha;
        int         nfull, nstart, l0, w, i;
        logic [7:0] rw;
        cpol   = (m / 2) == 1;
        cpha   = (m % 2) == 1;
        nfull  = nbits / 8;
        nstart = (nbits + 7) / 8;
        for (int k = 0; k < nfull; k++) exp_rx.push_back(mw[k]);
        txq.delete();
        for (int k = 1; k < tw.size(); k++) txq.push_back(tw[k]);
        txd[m]  = tw[0];
        l0      = load_cnt[m];
        rw      = '0;
        mosi[m] = mw[0][7];
        cs_n[m] = 1'b0;
        #HALF;
        check("busy_oe_active", m, {busy[m], oe[m]}, 2'b11);
        for (int b = 0; b < nbits; b++) begin
            w = b / 8;
            i = 7 - (b % 8);
            if (cpha) begin
                sclk[m] = ~cpol;
                mosi[m] = mw[w][i];
                #HALF;
                sclk[m] = cpol;
                rw = {rw[6:0], miso[m]};
                #HALF;
            end else begin
                sclk[m] = ~cpol;
                rw = {rw[6:0], miso[m]};
                #HALF;
                sclk[m] = cpol;
                if (b == nbits - 1) cs_n[m] = !do_rst;
                else mosi[m] = mw[(b + 1) / 8][7 - ((b + 1) % 8)];
                #HALF;
            end
            if (b % 8 == 7) check("miso_word", m, rw, tw[w]);
        end
        if (do_rst) begin
            check("busy_before_rst", m, busy[m], 1'b1);
            rstn = 1'b0;
            #1;
            check("rst_outputs", m, {miso[m], oe[m], busy[m], load[m], rxv[m]}, 0);
            check("rst_rx_data", m, rxd[m], 0);
            cs_n[m] = 1'b1;
            sclk[m] = cpol;
            #(HALF - 1);
            rstn = 1'b1;
            #HALF;
        end else begin
            cs_n[m] = 1'b1;
            #(2 * HALF);
        end
        check("idle_outputs", m, {miso[m], oe[m], busy[m]}, 0);
        check("tx_loads", m, load_cnt[m] - l0, nstart);
    endtask

    task automatic idle_toggle(input int m);
        int l0;
        l0 = load_cnt[m];
        for (int k = 0; k < 16; k++) begin
            sclk[m] = ~sclk[m];
            mosi[m] = 1'($urandom);
            #HALF;
            check("oe_busy_unselected", m, {oe[m], busy[m]}, 0);
        end
        check("tx_loads_unselected", m, load_cnt[m] - l0, 0);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0;
        cs_n = '1;
        mosi = '0;
        txd  = '0;
        for (int m = 0; m < 4; m++) sclk[m] = (m / 2) == 1;
        fork
            forever begin
                @(negedge clk);
                for (int m = 0; m < 4; m++) begin
                    if (load[m] === 1'b1) load_cnt[m]++;
                    if (rxv[m] === 1'b1) begin
                        if (exp_rx.size() == 0) check("rx_unexpected", m, rxv[m], 0);
                        else check("rx_data", m, rxd[m], exp_rx.pop_front());
                    end
                end
            end
            begin : feeder
                int lm;
                forever begin
                    @(negedge clk);
                    lm = -1;
                    for (int m = 0; m < 4; m++) if (load[m] === 1'b1) lm = m;
                    if (lm >= 0) begin
                        @(posedge clk);
                        #1;
                        txd[lm] = (txq.size() > 0) ? txq.pop_front() : 8'($urandom);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check("reset_state", m, {miso[m], oe[m], busy[m], load[m], rxv[m]}, 0);
            check("reset_rx_data", m, rxd[m], 0);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int m = 0; m < 4; m++) begin
            mw = '{8'h3C};
            tw = '{8'hA5};
            xfer(m, 8, 1'b0);
            mw = '{8'h01, 8'h02, 8'h03};
            tw = '{8'h11, 8'h22, 8'h33};
            xfer(m, 24, 1'b0);
            mw = '{8'($urandom)};
            tw = '{8'($urandom)};
            xfer(m, 5, 1'b0);
            check("rx_hold_after_partial", m, rxd[m], 8'h03);
            mw = '{8'hC3};
            tw = '{8'($urandom)};
            xfer(m, 8, 1'b0);
            idle_toggle(m);
            repeat (4) begin
                n = $urandom_range(1, 3);
                mw.delete();
                tw.delete();
                for (int k = 0; k < n; k++) begin
                    mw.push_back(8'($urandom));
                    tw.push_back(8'($urandom));
                end
                xfer(m, 8 * n, 1'b0);
            end
        end

        for (int m = 0; m < 4; m++) begin
            mw = '{8'($urandom)};
            tw = '{8'($urandom)};
            xfer(m, 4, 1'b1);
            mw = '{8'h5A};
            tw = '{8'h96};
            xfer(m, 8, 1'b0);
        end

        #HALF;
        check("rx_pending", 0, exp_rx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
